mdu_ctrl: RTL
=============

Name: mdu_ctrl

Overview:
Multi-cycle controller for the multiply/divide unit and the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU from the EX stage and runs an iterative radix-2 shift-add multiply or restoring divide, one bit per cycle.
- Stalls the pipeline while busy and commits the 64-bit result into HI/LO.
- Also serves MTHI/MTLO writes and drives HI/LO reads for MFHI/MFLO.

Parameters:
DATA_W, 32, operand width; HI/LO width; iteration count = DATA_W.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  EX stage holds a mul/div instruction; level signal, held while stall_o=1.
op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start in IDLE.
a  in  DATA_W  rs operand; dividend / multiplicand.
b  in  DATA_W  rt operand; divisor / multiplier.
flush  in  1  cancel any in-flight operation (exception/branch flush of EX).
hi_we  in  1  MTHI write enable.
lo_we  in  1  MTLO write enable.
wdata  in  DATA_W  MTHI/MTLO data.
stall_o  out  1  pipeline stall request.
done_o  out  1  one-cycle pulse in the commit cycle.
hi_o  out  DATA_W  HI register.
lo_o  out  DATA_W  LO register.

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, hi_o=0, lo_o=0, working regs=0, stall_o=0, done_o=0. Reset mid-operation abandons the operation; HI/LO read 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 and flush=0: latch op, the sign flags (sa=a[DATA_W-1], sb=b[DATA_W-1]; signed ops only) and the magnitudes of a and b (two's-complement absolute value for signed ops, raw for unsigned). Then cnt<=0 and go to MUL (op[1]=0) or DIV (op[1]=1).
  - stall_o is asserted combinationally in this cycle: stall_o = (IDLE & start & ~flush) | MUL | DIV.
- MUL: one shift-add step per cycle on a 2*DATA_W accumulator. After DATA_W steps (cnt==DATA_W-1), go to DONE.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). After DATA_W steps, go to DONE.
- DONE:
  - stall_o=0 and done_o=1; the EX stage advances this cycle.
  - Sign fixup: product negated if sa^sb (signed MULT). Quotient negated if sa^sb; remainder takes the sign of sa (signed DIV).
  - Commit at the clock edge that ends DONE: MUL gives {hi,lo}=product; DIV gives lo=quotient, hi=remainder. Next state is IDLE.
  - start is ignored in DONE, so the held instruction does not retrigger.
- Latency:
  - start seen in cycle 0.
  - MUL/DIV occupy cycles 1..DATA_W.
  - DONE is cycle DATA_W+1.
  - stall_o is high for DATA_W+1 cycles. HI/LO are visible from cycle DATA_W+2.
- Divide by zero (b==0): no trap. Result is hi=a (unmodified input), lo={DATA_W{1'b1}}, for both signed and unsigned.
- Signed corner case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- flush:
  - In MUL/DIV: return to IDLE next edge, no commit, stall_o=0 from the next cycle.
  - In DONE: done_o=0, no commit.
  - In IDLE: blocks start.
- MTHI/MTLO:
  - hi_we/lo_we write hi_o/lo_o at the edge in any state.
  - If a write coincides with a DONE commit, the commit wins, since the MDU instruction is younger in program order.

Optional Feature:
MDU_DIV_EN
- Defined: behaviour as above.
- Undefined: the DIV state and divider datapath are not compiled. start with op[1]=1 is treated as a no-op: no stall, no done_o, HI/LO unchanged.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> stall_o high exactly 33 cycles, done_o pulse, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; start held through DONE does not restart (state IDLE after).
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=0x12345678, b=0 -> hi=0x12345678, lo=0xFFFFFFFF.
- MULT in progress, flush at cycle 10 -> stall_o=0 at cycle 11, no done_o, HI/LO keep prior values (preloaded via MTHI/MTLO 0xAAAA0000/0x5555).
- hi_we=1, wdata=0x1111 in the DONE cycle of MULTU 2*3 -> hi=0, lo=6 (commit wins); hi_we in IDLE -> hi=0x1111 next cycle.
- rst pulsed asynchronously mid-DIV -> outputs 0 immediately; next start runs normally.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide controller with the HI/LO register pair.
// The divider is compiled only when MDU_DIV_EN is defined; otherwise DIV/DIVU are no-ops.
module mdu_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    // state | meaning
    // IDLE  | waiting for start; MTHI/MTLO only
    // MUL   | one shift-add step per cycle
    // DIV   | one restoring-divide step per cycle
    // DONE  | sign fixup, done_o pulse, commit on exit
`ifdef MDU_DIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  sa;
    logic                  sb;
    logic [DATA_W-1:0]     opnd;
    logic [2*DATA_W-1:0]   acc;
`ifdef MDU_DIV_EN
    logic                  is_div;
    logic                  bz;
`endif

    logic                  sgn;
    logic                  accept;
    logic [DATA_W-1:0]     abs_a;
    logic [DATA_W-1:0]     abs_b;
    logic [DATA_W:0]       mul_sum;
    logic [2*DATA_W-1:0]   mul_next;
    logic [2*DATA_W-1:0]   prod;
    logic [DATA_W-1:0]     res_hi;
    logic [DATA_W-1:0]     res_lo;
    logic                  last;

    assign sgn   = ~op[0];
    assign abs_a = (sgn & a[DATA_W-1]) ? -a : a;
    assign abs_b = (sgn & b[DATA_W-1]) ? -b : b;
    assign last  = (cnt == CNT_W'(DATA_W - 1));

`ifdef MDU_DIV_EN
    assign accept  = (state == IDLE) & start & ~flush;
    assign stall_o = accept | (state == MUL) | (state == DIV);
`else
    assign accept  = (state == IDLE) & start & ~flush & ~op[1];
    assign stall_o = accept | (state == MUL);
`endif
    assign done_o = (state == DONE) & ~flush;

    // Accumulator holds {partial product, remaining multiplier}; multiplier LSB selects the add.
    assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, (acc[0] ? opnd : {DATA_W{1'b0}})};
    assign mul_next = {mul_sum, acc[DATA_W-1:1]};

`ifdef MDU_DIV_EN
    // Accumulator holds {remainder, dividend/quotient}; quotient bits shift in at the bottom.
    logic [DATA_W:0]       div_shift;
    logic [DATA_W+1:0]     div_diff;
    logic [2*DATA_W-1:0]   div_next;
    logic [DATA_W-1:0]     quo;
    logic [DATA_W-1:0]     rem;

    assign div_shift = acc[2*DATA_W-1:DATA_W-1];
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    assign div_next  = div_diff[DATA_W+1] ?
                       {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0} :
                       {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    assign quo = acc[DATA_W-1:0];
    assign rem = acc[2*DATA_W-1:DATA_W];
`endif

    always_comb begin
        prod   = (sa ^ sb) ? -acc : acc;
        res_hi = prod[2*DATA_W-1:DATA_W];
        res_lo = prod[DATA_W-1:0];
`ifdef MDU_DIV_EN
        // A zero divisor leaves the dividend in the remainder, so the sa fixup restores a.
        if (is_div) begin
            res_hi = sa ? -rem : rem;
            res_lo = bz ? {DATA_W{1'b1}} : ((sa ^ sb) ? -quo : quo);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            hi_o   <= '0;
            lo_o   <= '0;
`ifdef MDU_DIV_EN
            is_div <= 1'b0;
            bz     <= 1'b0;
`endif
        end else begin
            if (hi_we) hi_o <= wdata;
            if (lo_we) lo_o <= wdata;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sa  <= sgn & a[DATA_W-1];
                        sb  <= sgn & b[DATA_W-1];
                        cnt <= '0;
`ifdef MDU_DIV_EN
                        is_div <= op[1];
                        bz     <= (b == '0);
                        if (op[1]) begin
                            opnd  <= abs_b;
                            acc   <= {{DATA_W{1'b0}}, abs_a};
                            state <= DIV;
                        end else begin
                            opnd  <= abs_a;
                            acc   <= {{DATA_W{1'b0}}, abs_b};
                            state <= MUL;
                        end
`else
                        opnd  <= abs_a;
                        acc   <= {{DATA_W{1'b0}}, abs_b};
                        state <= MUL;
`endif
                    end
                end
                MUL: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= mul_next;
                        cnt <= cnt + CNT_W'(1);
                        if (last) state <= DONE;
                    end
                end
`ifdef MDU_DIV_EN
                DIV: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= div_next;
                        cnt <= cnt + CNT_W'(1);
                        if (last) state <= DONE;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                    // Placed after the MTHI/MTLO writes so the younger MDU result wins.
                    if (!flush) begin
                        hi_o <= res_hi;
                        lo_o <= res_lo;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
